// File: rtl/alu_pkg.sv
// Opcodes and FSM states shared by seq_alu and the decoder/control unit.
// Every 4-bit code is assigned, so there is no illegal-opcode path anywhere.
package alu_pkg;

  localparam logic [3:0] OP_REMU  = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_JAL   = 4'b1001;
  localparam logic [3:0] OP_LUI   = 4'b1010;
  localparam logic [3:0] OP_SRA   = 4'b1011;
  localparam logic [3:0] OP_SLTU  = 4'b1100;
  localparam logic [3:0] OP_MUL   = 4'b1101;
  localparam logic [3:0] OP_MULHU = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Opcodes that run through the iterative multiplier/divider
  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing a 2*WIDTH accumulator.
// Multiply leaves the product in {hi,lo}; divide leaves quotient in lo and remainder in hi.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_mul_q, is_mul_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH-1:0]   div_diff;

  always_comb begin
    acc_d    = acc_q;
    opd_d    = opd_q;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
    div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_rem[WIDTH-1:0] - opd_q;

    if (start) begin
      // Multiply keeps the multiplicand aside and shifts the multiplier through acc;
      // divide keeps the divisor aside and shifts the dividend through acc.
      is_mul_d = (op == OP_MUL) || (op == OP_MULHU);
      opd_d    = is_mul_d ? a : b;
      acc_d    = {{WIDTH{1'b0}}, (is_mul_d ? b : a)};
      cnt_d    = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (is_mul_q) begin
        if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
      end else begin
        // A zero divisor always "fits", giving all-ones quotient and remainder = dividend
        if (div_rem >= {1'b0, opd_q}) acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
        else                          acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      opd_q    <= '0;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
    end
  end

  assign done = (cnt_q == CW'(1));
  assign lo   = acc_q[WIDTH-1:0];
  assign hi   = acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU with valid/ready on both sides; results and zero flag
// are registered one cycle after the operation completes and held until consumed.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag
);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SHW-1:0]          sh;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      OP_SRA:  return sa >>> sh;
      OP_SLT:  return {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_SLTU: return {{(WIDTH-1){1'b0}}, (a < b)};
      OP_JAL:  return b + WIDTH'(4);
      OP_LUI:  return b << 12;
      default: return '0;
    endcase
  endfunction

  assign in_ready = (state_q == IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign md_start = accept && is_iter(operation);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .op    (operation),
    .a     (operand1),
    .b     (operand2),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = operation;
          a_d     = operand1;
          b_d     = operand2;
          state_d = is_iter(operation) ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (md_done) state_d = DONE;
      end
      DONE: begin
        // First DONE cycle registers the outputs; afterwards wait for the consumer
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          zero_d      = (a_q == b_q);
          if (is_iter(op_q))
            result_d = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? md_lo : md_hi;
          else
            result_d = alu_single(op_q, a_q, b_q);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero_flag = zero_q;

endmodule
